// File: rtl/xbar_master_interface.sv
// Slave-port endpoint of the crossbar: arbitrates decoded AR/AW requests from the
// master interfaces, buffers them to the outer AXI slave, and routes R/B back by ID.
module xbar_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    // Full always refuses a push, even when a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (do_pop)
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

module xbar_master_interface #(
    parameter int ID_WIDTH          = 4,
    parameter int IDS_WIDTH         = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int LEN_WIDTH         = 4,
    parameter int SIZE_WIDTH        = 3,
    parameter int DATA_WIDTH        = 32,
    parameter int STRB_WIDTH        = 4,
    parameter int pending_depth     = 8,
    parameter int masters           = 2,
    parameter int slaves            = 2,
    parameter int i_am_slave_number = 0
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    // AR from master interfaces
    input  logic [ID_WIDTH-1:0]          ARID    [0:masters-1],
    input  logic [ADDR_WIDTH-1:0]        ARADDR  [0:masters-1],
    input  logic [LEN_WIDTH-1:0]         ARLEN   [0:masters-1],
    input  logic [SIZE_WIDTH-1:0]        ARSIZE  [0:masters-1],
    input  logic [1:0]                   ARBURST [0:masters-1],
    input  logic                         master_read_addr_fifo_empty  [0:masters-1],
    input  logic [$clog2(slaves)-1:0]    read_addr_forward_dest_slave [0:masters-1],
    output logic [$clog2(masters):0]     slave_grant_read_addr_master_number,
    output logic                         slave_read_addr_push_to_fifo,
    output logic                         slave_read_addr_fifo_full,
    // AW from master interfaces
    input  logic [ID_WIDTH-1:0]          AWID    [0:masters-1],
    input  logic [ADDR_WIDTH-1:0]        AWADDR  [0:masters-1],
    input  logic [LEN_WIDTH-1:0]         AWLEN   [0:masters-1],
    input  logic [SIZE_WIDTH-1:0]        AWSIZE  [0:masters-1],
    input  logic [1:0]                   AWBURST [0:masters-1],
    input  logic                         master_write_addr_fifo_empty  [0:masters-1],
    input  logic [$clog2(slaves)-1:0]    write_addr_forward_dest_slave [0:masters-1],
    output logic [$clog2(masters):0]     slave_grant_write_addr_master_number,
    output logic                         slave_write_addr_push_to_fifo,
    output logic                         slave_write_addr_fifo_full,
    // W from master interfaces
    input  logic [DATA_WIDTH-1:0]        WDATA [0:masters-1],
    input  logic [STRB_WIDTH-1:0]        WSTRB [0:masters-1],
    input  logic                         WLAST [0:masters-1],
    input  logic                         master_write_data_fifo_empty [0:masters-1],
    output logic                         slave_write_data_fifo_full   [0:masters-1],
    // R toward master interfaces
    output logic [ID_WIDTH-1:0]          RID,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         slave_read_data_fifo_empty,
    output logic [$clog2(masters)-1:0]   read_data_return_dest_master,
    input  logic [$clog2(slaves):0]      grant_read_data_return_slave [0:masters-1],
    input  logic                         master_read_data_push_to_fifo [0:masters-1],
    input  logic                         master_read_data_fifo_full    [0:masters-1],
    // B toward master interfaces
    output logic [ID_WIDTH-1:0]          BID,
    output logic [1:0]                   BRESP,
    output logic                         slave_write_resp_fifo_empty,
    output logic [$clog2(masters)-1:0]   write_resp_return_dest_master,
    input  logic [$clog2(slaves):0]      grant_write_resp_return_slave [0:masters-1],
    input  logic                         master_write_resp_push_to_fifo [0:masters-1],
    input  logic                         master_write_resp_fifo_full    [0:masters-1],
    // Outer AXI slave
    output logic [IDS_WIDTH-1:0]         ARID_S,
    output logic [ADDR_WIDTH-1:0]        ARADDR_S,
    output logic [LEN_WIDTH-1:0]         ARLEN_S,
    output logic [SIZE_WIDTH-1:0]        ARSIZE_S,
    output logic [1:0]                   ARBURST_S,
    output logic                         ARVALID_S,
    input  logic                         ARREADY_S,
    output logic [IDS_WIDTH-1:0]         AWID_S,
    output logic [ADDR_WIDTH-1:0]        AWADDR_S,
    output logic [LEN_WIDTH-1:0]         AWLEN_S,
    output logic [SIZE_WIDTH-1:0]        AWSIZE_S,
    output logic [1:0]                   AWBURST_S,
    output logic                         AWVALID_S,
    input  logic                         AWREADY_S,
    output logic [DATA_WIDTH-1:0]        WDATA_S,
    output logic [STRB_WIDTH-1:0]        WSTRB_S,
    output logic                         WLAST_S,
    output logic                         WVALID_S,
    input  logic                         WREADY_S,
    input  logic [IDS_WIDTH-1:0]         RID_S,
    input  logic [DATA_WIDTH-1:0]        RDATA_S,
    input  logic [1:0]                   RRESP_S,
    input  logic                         RLAST_S,
    input  logic                         RVALID_S,
    output logic                         RREADY_S,
    input  logic [IDS_WIDTH-1:0]         BID_S,
    input  logic [1:0]                   BRESP_S,
    input  logic                         BVALID_S,
    output logic                         BREADY_S
);
    localparam int MW  = $clog2(masters);
    localparam int GW  = MW + 1;
    localparam int SW  = $clog2(slaves);
    localparam int GSW = SW + 1;
    localparam int AW_W = IDS_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + 2;
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int R_W  = IDS_WIDTH + DATA_WIDTH + 2 + 1;
    localparam int B_W  = IDS_WIDTH + 2;
    localparam logic [GW-1:0] NONE = GW'(masters);

    // Search starts at ptr; iterating downward lets the closest requester win.
    function automatic logic [GW-1:0] rr_pick(input logic [masters-1:0] req,
                                              input logic [MW-1:0] ptr);
        logic [GW-1:0] g;
        int idx;
        g = NONE;
        for (int i = masters - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % masters;
            if (req[idx]) g = GW'(idx);
        end
        return g;
    endfunction

    // Holds grants and the return-path ready low while reset is asserted.
    logic run_q, run_d;
    assign run_d = 1'b1;

    logic [masters-1:0] ar_req, aw_req;
    logic [GW-1:0]      ar_grant, aw_grant;
    logic [MW-1:0]      ar_gi, aw_gi, ar_ptr_q, ar_ptr_d, aw_ptr_q, aw_ptr_d;
    logic [IDS_WIDTH-1:0] ar_ids, aw_ids;
    logic               ar_push, aw_push, ar_full, aw_full, ar_empty, aw_empty;
    logic [AW_W-1:0]    ar_head, aw_head;
    logic               wo_full, wo_empty, wo_pop;
    logic [MW-1:0]      wo_h;
    logic               w_push, w_full, w_empty;
    logic [W_W-1:0]     w_head;
    logic               r_full, r_empty, r_pop, r_dv;
    logic [R_W-1:0]     r_head;
    logic [IDS_WIDTH-1:0] r_hid, b_hid;
    logic [MW-1:0]      r_d, r_di, b_d, b_di;
    logic               b_full, b_empty, b_pop, b_dv;
    logic [B_W-1:0]     b_head;

    always_comb begin
        for (int m = 0; m < masters; m++) begin
            ar_req[m] = run_q & ~master_read_addr_fifo_empty[m]
                      & (read_addr_forward_dest_slave[m] == SW'(i_am_slave_number));
            aw_req[m] = run_q & ~master_write_addr_fifo_empty[m]
                      & (write_addr_forward_dest_slave[m] == SW'(i_am_slave_number));
        end
        ar_grant = rr_pick(ar_req, ar_ptr_q);
        aw_grant = rr_pick(aw_req, aw_ptr_q);
        ar_gi    = (ar_grant == NONE) ? '0 : ar_grant[MW-1:0];
        aw_gi    = (aw_grant == NONE) ? '0 : aw_grant[MW-1:0];
        ar_push  = (ar_grant != NONE) & ~ar_full;
        aw_push  = (aw_grant != NONE) & ~aw_full & ~wo_full;
        ar_ptr_d = ar_push ? MW'((int'(ar_gi) + 1) % masters) : ar_ptr_q;
        aw_ptr_d = aw_push ? MW'((int'(aw_gi) + 1) % masters) : aw_ptr_q;
        // Master number goes just above the master-side ID.
        ar_ids = '0;
        ar_ids[ID_WIDTH +: MW]   = ar_gi;
        ar_ids[ID_WIDTH-1:0]     = ARID[ar_gi];
        aw_ids = '0;
        aw_ids[ID_WIDTH +: MW]   = aw_gi;
        aw_ids[ID_WIDTH-1:0]     = AWID[aw_gi];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            run_q    <= 1'b0;
            ar_ptr_q <= '0;
            aw_ptr_q <= '0;
        end else begin
            run_q    <= run_d;
            ar_ptr_q <= ar_ptr_d;
            aw_ptr_q <= aw_ptr_d;
        end
    end

    assign slave_grant_read_addr_master_number  = ar_grant;
    assign slave_read_addr_push_to_fifo         = ar_push;
    assign slave_read_addr_fifo_full            = ar_full;
    assign slave_grant_write_addr_master_number = aw_grant;
    assign slave_write_addr_push_to_fifo        = aw_push;
    assign slave_write_addr_fifo_full           = aw_full;

    xbar_fifo #(.WIDTH(AW_W), .DEPTH(pending_depth)) u_ar_fifo (
        .clk(ACLK), .rst_n(ARESETn), .push(ar_push), .pop(ARREADY_S),
        .din({ar_ids, ARADDR[ar_gi], ARLEN[ar_gi], ARSIZE[ar_gi], ARBURST[ar_gi]}),
        .dout(ar_head), .empty(ar_empty), .full(ar_full));
    assign {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} = ar_head;
    assign ARVALID_S = ~ar_empty;

    xbar_fifo #(.WIDTH(AW_W), .DEPTH(pending_depth)) u_aw_fifo (
        .clk(ACLK), .rst_n(ARESETn), .push(aw_push), .pop(AWREADY_S),
        .din({aw_ids, AWADDR[aw_gi], AWLEN[aw_gi], AWSIZE[aw_gi], AWBURST[aw_gi]}),
        .dout(aw_head), .empty(aw_empty), .full(aw_full));
    assign {AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S} = aw_head;
    assign AWVALID_S = ~aw_empty;

    // W-order FIFO: which master owns the next W burst, in AW acceptance order.
    xbar_fifo #(.WIDTH(MW), .DEPTH(pending_depth)) u_wo_fifo (
        .clk(ACLK), .rst_n(ARESETn), .push(aw_push), .pop(wo_pop),
        .din(aw_gi), .dout(wo_h), .empty(wo_empty), .full(wo_full));

    always_comb begin
        for (int k = 0; k < masters; k++)
            slave_write_data_fifo_full[k] = wo_empty | (wo_h != MW'(k)) | w_full;
    end
    assign w_push = ~wo_empty & ~w_full & ~master_write_data_fifo_empty[wo_h];
    assign wo_pop = w_push & WLAST[wo_h];

    xbar_fifo #(.WIDTH(W_W), .DEPTH(pending_depth)) u_w_fifo (
        .clk(ACLK), .rst_n(ARESETn), .push(w_push), .pop(WREADY_S),
        .din({WDATA[wo_h], WSTRB[wo_h], WLAST[wo_h]}),
        .dout(w_head), .empty(w_empty), .full(w_full));
    assign {WDATA_S, WSTRB_S, WLAST_S} = w_head;
    assign WVALID_S = ~w_empty;

    assign RREADY_S = run_q & ~r_full;
    assign BREADY_S = run_q & ~b_full;

    xbar_fifo #(.WIDTH(R_W), .DEPTH(pending_depth)) u_r_fifo (
        .clk(ACLK), .rst_n(ARESETn), .push(RVALID_S & RREADY_S), .pop(r_pop),
        .din({RID_S, RDATA_S, RRESP_S, RLAST_S}),
        .dout(r_head), .empty(r_empty), .full(r_full));
    assign {r_hid, RDATA, RRESP, RLAST} = r_head;

    xbar_fifo #(.WIDTH(B_W), .DEPTH(pending_depth)) u_b_fifo (
        .clk(ACLK), .rst_n(ARESETn), .push(BVALID_S & BREADY_S), .pop(b_pop),
        .din({BID_S, BRESP_S}),
        .dout(b_head), .empty(b_empty), .full(b_full));
    assign {b_hid, BRESP} = b_head;

    // A head whose master field names no real master is popped and dropped.
    always_comb begin
        r_d   = r_hid[ID_WIDTH +: MW];
        r_dv  = int'(r_d) < masters;
        r_di  = r_dv ? r_d : '0;
        r_pop = ~r_empty & (~r_dv
              | ((grant_read_data_return_slave[r_di] == GSW'(i_am_slave_number))
                 & master_read_data_push_to_fifo[r_di] & ~master_read_data_fifo_full[r_di]));
        b_d   = b_hid[ID_WIDTH +: MW];
        b_dv  = int'(b_d) < masters;
        b_di  = b_dv ? b_d : '0;
        b_pop = ~b_empty & (~b_dv
              | ((grant_write_resp_return_slave[b_di] == GSW'(i_am_slave_number))
                 & master_write_resp_push_to_fifo[b_di] & ~master_write_resp_fifo_full[b_di]));
    end

    assign RID                           = r_hid[ID_WIDTH-1:0];
    assign read_data_return_dest_master  = r_d;
    assign slave_read_data_fifo_empty    = r_empty;
    assign BID                           = b_hid[ID_WIDTH-1:0];
    assign write_resp_return_dest_master = b_d;
    assign slave_write_resp_fifo_empty   = b_empty;

    generate
        if (IDS_WIDTH > ID_WIDTH + MW) begin : g_pad
            logic unused_id_pad;
            assign unused_id_pad = ^{r_hid[IDS_WIDTH-1:ID_WIDTH+MW], b_hid[IDS_WIDTH-1:ID_WIDTH+MW]};
        end
    endgenerate
endmodule
